// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder
//
// Snoop responder on the cached-master side of an ACE interface. It accepts
// one AC snoop at a time, looks the line up in the local cache, returns a CR
// response, streams the line on CD when the response carries data, and then
// issues the resulting cache-state update (invalidate or make clean-shared).
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   ac_*                   snoop request (valid/ready, address, ACSNOOP, prot unused)
//   cr_*                   snoop response {WasUnique, IsShared, PassDirty, Error, DataTransfer}
//   cd_*                   snoop data burst (CdBeats beats, last on final beat)
//   lookup_*               tag lookup request (valid/ready) and its later result
//   rd_en_o/rd_beat_o/rd_data_i
//                          data-array read port, data returns one cycle after rd_en_o
//   upd_*                  cache-state update request (01 invalidate, 10 make clean-shared)

module ace_snoop_responder #(
    parameter int AddrWidth    = 64,
    parameter int DataWidth    = 64,
    parameter int CdBeats      = 4,
    parameter int BeatIdxWidth = (CdBeats > 1) ? $clog2(CdBeats) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ac_valid_i,
    output logic                    ac_ready_o,
    input  logic [AddrWidth-1:0]    ac_addr_i,
    input  logic [3:0]              ac_snoop_i,
    input  logic [2:0]              ac_prot_i,
    output logic                    cr_valid_o,
    input  logic                    cr_ready_i,
    output logic [4:0]              cr_resp_o,
    output logic                    cd_valid_o,
    input  logic                    cd_ready_i,
    output logic [DataWidth-1:0]    cd_data_o,
    output logic                    cd_last_o,
    output logic                    lookup_valid_o,
    input  logic                    lookup_ready_i,
    output logic [AddrWidth-1:0]    lookup_addr_o,
    input  logic                    lookup_rsp_valid_i,
    input  logic                    lookup_hit_i,
    input  logic                    lookup_dirty_i,
    input  logic                    lookup_shared_i,
    output logic                    rd_en_o,
    output logic [BeatIdxWidth-1:0] rd_beat_o,
    input  logic [DataWidth-1:0]    rd_data_i,
    output logic                    upd_valid_o,
    input  logic                    upd_ready_i,
    output logic [AddrWidth-1:0]    upd_addr_o,
    output logic [1:0]              upd_op_o
);

    localparam int CntWidth = BeatIdxWidth + 1;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_INVAL = 2'b01;
    localparam logic [1:0] OP_CLEAN = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WAIT_RSP,
        S_CR,
        S_DATA,
        S_UPD
    } state_e;

    // Returns {op[1:0], resp[4:0]}; resp = {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
    function automatic logic [6:0] snoop_decode(input logic [3:0] snoop,
                                                input logic hit,
                                                input logic dirty,
                                                input logic shared);
        logic [4:0] resp;
        logic [1:0] op;
        resp = 5'b00000;
        op   = OP_NONE;
        if (hit) begin
            case (snoop)
                4'b0000: resp = 5'b01001;
                4'b0001, 4'b0010, 4'b0011: begin
                    resp = {1'b0, 1'b1, dirty, 1'b0, 1'b1};
                    op   = dirty ? OP_CLEAN : OP_NONE;
                end
                4'b0111: begin
                    resp = {~shared, 1'b0, dirty, 1'b0, 1'b1};
                    op   = OP_INVAL;
                end
                4'b1000: begin
                    resp = {1'b0, 1'b1, dirty, 1'b0, dirty};
                    op   = dirty ? OP_CLEAN : OP_NONE;
                end
                4'b1001: begin
                    resp = {~shared, 1'b0, dirty, 1'b0, dirty};
                    op   = OP_INVAL;
                end
                4'b1101: op = OP_INVAL;
                default: resp = 5'b00010;
            endcase
        end
        return {op, resp};
    endfunction

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [3:0]             snoop_q, snoop_d;
    logic [4:0]             resp_q, resp_d;
    logic [1:0]             op_q, op_d;
    logic                   ac_ready_q, ac_ready_d;
    logic                   lookup_valid_q, lookup_valid_d;
    logic                   cr_valid_q, cr_valid_d;
    logic                   upd_valid_q, upd_valid_d;
    logic [CntWidth-1:0]    rd_cnt_q, rd_cnt_d;       // reads issued so far
    logic [BeatIdxWidth-1:0] cd_beat_q, cd_beat_d;    // beat index at the buffer head
    logic                   rd_inflight_q, rd_inflight_d;
    logic [DataWidth-1:0]   buf_q [2];
    logic [DataWidth-1:0]   buf_d [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             count_q, count_d;

    logic       ac_hs, lookup_hs, cr_hs, cd_hs, upd_hs;
    logic       push, pop;
    logic [2:0] occ_after;
    logic       rd_en_raw;
    logic       unused_prot;

    assign unused_prot = ^ac_prot_i;

    assign ac_ready_o     = ac_ready_q;
    assign lookup_valid_o = lookup_valid_q;
    assign lookup_addr_o  = addr_q;
    assign cr_valid_o     = cr_valid_q;
    assign cr_resp_o      = resp_q;
    assign upd_valid_o    = upd_valid_q;
    assign upd_addr_o     = addr_q;
    assign upd_op_o       = op_q;

    assign cd_valid_o = (count_q != 2'd0);
    assign cd_data_o  = buf_q[rd_ptr_q];
    assign cd_last_o  = cd_valid_o && (cd_beat_q == BeatIdxWidth'(CdBeats - 1));
    assign rd_beat_o  = rd_cnt_q[BeatIdxWidth-1:0];

    assign ac_hs     = ac_valid_i && ac_ready_q;
    assign lookup_hs = lookup_valid_q && lookup_ready_i;
    assign cr_hs     = cr_valid_q && cr_ready_i;
    assign cd_hs     = cd_valid_o && cd_ready_i;
    assign upd_hs    = upd_valid_q && upd_ready_i;

    // Data arriving this cycle fills a slot, a CD handshake frees one. A new
    // read is only issued if, after both, one slot is still free for it; the
    // pop term is what lets the stream run without gaps under cd_ready_i=1.
    assign push      = rd_inflight_q;
    assign pop       = cd_hs;
    assign occ_after = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};
    assign rd_en_raw = (state_q == S_DATA) &&
                       (rd_cnt_q < CntWidth'(CdBeats)) &&
                       (occ_after <= 3'd1);
    assign rd_en_o   = rd_en_raw && !rst_i;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        snoop_d       = snoop_q;
        resp_d        = resp_q;
        op_d          = op_q;
        rd_cnt_d      = rd_cnt_q;
        cd_beat_d     = cd_beat_q;
        rd_inflight_d = rd_en_o;
        buf_d         = buf_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        case (state_q)
            S_IDLE: begin
                if (ac_hs) begin
                    addr_d  = ac_addr_i;
                    snoop_d = ac_snoop_i;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lookup_hs) begin
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (lookup_rsp_valid_i) begin
                    {op_d, resp_d} = snoop_decode(snoop_q, lookup_hit_i,
                                                  lookup_dirty_i, lookup_shared_i);
                    state_d = S_CR;
                end
            end
            S_CR: begin
                if (cr_hs) begin
                    if (resp_q[0]) begin
                        state_d = S_DATA;
                    end else if (op_q != OP_NONE) begin
                        state_d = S_UPD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (rd_en_raw) begin
                    rd_cnt_d = rd_cnt_q + CntWidth'(1);
                end
                if (push) begin
                    buf_d[wr_ptr_q] = rd_data_i;
                    wr_ptr_d        = ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_d  = ~rd_ptr_q;
                    cd_beat_d = cd_beat_q + BeatIdxWidth'(1);
                end
                count_d = 2'(occ_after);
                // Last beat accepted: every read has already drained, so the
                // buffer is empty and the counters can be rearmed here.
                if (pop && cd_last_o) begin
                    state_d   = (op_q != OP_NONE) ? S_UPD : S_IDLE;
                    rd_cnt_d  = '0;
                    cd_beat_d = '0;
                    wr_ptr_d  = 1'b0;
                    rd_ptr_d  = 1'b0;
                    count_d   = 2'd0;
                end
            end
            S_UPD: begin
                if (upd_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake outputs are registered images of the next state.
        ac_ready_d     = (state_d == S_IDLE);
        lookup_valid_d = (state_d == S_LOOKUP);
        cr_valid_d     = (state_d == S_CR);
        upd_valid_d    = (state_d == S_UPD);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            snoop_q        <= '0;
            resp_q         <= '0;
            op_q           <= OP_NONE;
            ac_ready_q     <= 1'b0;
            lookup_valid_q <= 1'b0;
            cr_valid_q     <= 1'b0;
            upd_valid_q    <= 1'b0;
            rd_cnt_q       <= '0;
            cd_beat_q      <= '0;
            rd_inflight_q  <= 1'b0;
            buf_q[0]       <= '0;
            buf_q[1]       <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            snoop_q        <= snoop_d;
            resp_q         <= resp_d;
            op_q           <= op_d;
            ac_ready_q     <= ac_ready_d;
            lookup_valid_q <= lookup_valid_d;
            cr_valid_q     <= cr_valid_d;
            upd_valid_q    <= upd_valid_d;
            rd_cnt_q       <= rd_cnt_d;
            cd_beat_q      <= cd_beat_d;
            rd_inflight_q  <= rd_inflight_d;
            buf_q[0]       <= buf_d[0];
            buf_q[1]       <= buf_d[1];
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Scoreboard bench for ace_snoop_responder: expected CR/CD/update traffic is
// queued when a snoop is issued and compared as the DUT hands it off.

module tb_ace_snoop_responder;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int NB = 4;
    localparam int BW = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          ac_valid_i;
    logic          ac_ready_o;
    logic [AW-1:0] ac_addr_i;
    logic [3:0]    ac_snoop_i;
    logic [2:0]    ac_prot_i;
    logic          cr_valid_o;
    logic          cr_ready_i = 1'b0;
    logic [4:0]    cr_resp_o;
    logic          cd_valid_o;
    logic          cd_ready_i = 1'b0;
    logic [DW-1:0] cd_data_o;
    logic          cd_last_o;
    logic          lookup_valid_o;
    logic          lookup_ready_i;
    logic [AW-1:0] lookup_addr_o;
    logic          lookup_rsp_valid_i;
    logic          lookup_hit_i, lookup_dirty_i, lookup_shared_i;
    logic          rd_en_o;
    logic [BW-1:0] rd_beat_o;
    logic [DW-1:0] rd_data_i = '0;
    logic          upd_valid_o;
    logic          upd_ready_i = 1'b0;
    logic [AW-1:0] upd_addr_o;
    logic [1:0]    upd_op_o;

    ace_snoop_responder #(
        .AddrWidth(AW), .DataWidth(DW), .CdBeats(NB), .BeatIdxWidth(BW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
        .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
        .cd_last_o(cd_last_o),
        .lookup_valid_o(lookup_valid_o), .lookup_ready_i(lookup_ready_i),
        .lookup_addr_o(lookup_addr_o), .lookup_rsp_valid_i(lookup_rsp_valid_i),
        .lookup_hit_i(lookup_hit_i), .lookup_dirty_i(lookup_dirty_i),
        .lookup_shared_i(lookup_shared_i),
        .rd_en_o(rd_en_o), .rd_beat_o(rd_beat_o), .rd_data_i(rd_data_i),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i),
        .upd_addr_o(upd_addr_o), .upd_op_o(upd_op_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic [4:0]  exp_cr  [$];
    logic [64:0] exp_cd  [$];
    logic [65:0] exp_upd [$];
    int          fin_kind = 0;      // 0 CR, 1 CD, 2 UPD ends the transaction
    bit          chk_ready_next = 0;
    int          cd_hs_cnt = 0;
    int          upd_hs_cnt = 0;
    int          rd_cnt = 0;
    int          rd_exp_beat = 0;
    bit          bp_on = 0, rand_on = 0, force_cd_low = 0;
    int          bp_idx = 0;
    logic [DW-1:0] line_data [NB];

    // Ready generators for CR, CD and update channels.
    always @(posedge clk_i) begin
        logic [3:0] pat;
        #1;
        pat = 4'b1001;
        if (force_cd_low) cd_ready_i = 1'b0;
        else if (bp_on) begin
            cd_ready_i = pat[bp_idx[1:0]];
            bp_idx = (bp_idx + 1) % 4;
        end else cd_ready_i = 1'b1;
        cr_ready_i  = rand_on ? 1'($urandom_range(0, 1)) : 1'b1;
        upd_ready_i = rand_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Data array model: one-cycle read latency, poison when no read.
    always begin
        logic          fire;
        logic [BW-1:0] b;
        @(negedge clk_i);
        fire = rd_en_o;
        b    = rd_beat_o;
        if (rst_i) rd_exp_beat = 0;
        else if (fire) begin
            rd_cnt++;
            check("rd_beat", b, rd_exp_beat);
            rd_exp_beat = (rd_exp_beat + 1) % NB;
        end
        @(posedge clk_i);
        #1;
        rd_data_i = fire ? line_data[b] : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    // Output monitor.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (chk_ready_next) begin
                check("ac_ready_after", ac_ready_o, 1'b1);
                chk_ready_next = 0;
            end
            if (cr_valid_o) begin
                if (exp_cr.size() == 0) check("cr_unexpected", 1, 0);
                else begin
                    check("cr_resp", cr_resp_o, exp_cr[0]);
                    if (cr_ready_i) begin
                        void'(exp_cr.pop_front());
                        if (fin_kind == 0) chk_ready_next = 1;
                    end
                end
            end
            if (cd_valid_o) begin
                if (exp_cd.size() == 0) check("cd_unexpected", 1, 0);
                else begin
                    check("cd_beat", {cd_last_o, cd_data_o}, exp_cd[0]);
                    if (cd_ready_i) begin
                        void'(exp_cd.pop_front());
                        cd_hs_cnt++;
                        if (cd_last_o && fin_kind == 1) chk_ready_next = 1;
                    end
                end
            end
            if (upd_valid_o) begin
                if (exp_upd.size() == 0) check("upd_unexpected", 1, 0);
                else begin
                    check("upd", {upd_op_o, upd_addr_o}, exp_upd[0]);
                    if (upd_ready_i) begin
                        void'(exp_upd.pop_front());
                        upd_hs_cnt++;
                        if (fin_kind == 2) chk_ready_next = 1;
                    end
                end
            end
        end
    end

    task automatic start_snoop(input logic [3:0] sn, input logic [AW-1:0] addr,
                               input logic h, input logic d, input logic s);
        bit ok;
        @(posedge clk_i); #1;
        ac_valid_i = 1'b1; ac_addr_i = addr; ac_snoop_i = sn; ac_prot_i = 3'($urandom);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (ac_ready_o) begin ok = 1; break; end
        end
        if (!ok) check("ac_timeout", 0, 1);
        @(posedge clk_i); #1;
        ac_valid_i = 1'b0; ac_addr_i = '1; ac_snoop_i = 4'hF;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (lookup_valid_o) begin ok = 1; break; end
        end
        if (!ok) check("lookup_timeout", 0, 1);
        check("lookup_addr", lookup_addr_o, addr);
        @(posedge clk_i); #1; lookup_ready_i = 1'b1;
        @(posedge clk_i); #1; lookup_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        lookup_rsp_valid_i = 1'b1;
        lookup_hit_i = h; lookup_dirty_i = d; lookup_shared_i = s;
        @(posedge clk_i); #1;
        lookup_rsp_valid_i = 1'b0;
        lookup_hit_i = ~h; lookup_dirty_i = ~d; lookup_shared_i = ~s;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_i);
            #1;
            if (exp_cr.size() == 0 && exp_cd.size() == 0 && exp_upd.size() == 0 && ac_ready_o) begin
                ok = 1; break;
            end
        end
        if (!ok) begin
            check("done_timeout", 0, 1);
            exp_cr.delete(); exp_cd.delete(); exp_upd.delete();
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic push_expect(input logic [AW-1:0] addr, input logic [4:0] resp,
                               input logic [1:0] op, input logic [DW-1:0] base);
        for (int i = 0; i < NB; i++) line_data[i] = base + DW'(i);
        exp_cr.push_back(resp);
        if (resp[0])
            for (int i = 0; i < NB; i++) exp_cd.push_back({(i == NB - 1), base + DW'(i)});
        if (op != 2'b00) exp_upd.push_back({op, addr});
        fin_kind = (op != 2'b00) ? 2 : (resp[0] ? 1 : 0);
    endtask

    task automatic run_snoop(input logic [3:0] sn, input logic [AW-1:0] addr,
                             input logic h, input logic d, input logic s,
                             input logic [4:0] resp, input logic [1:0] op,
                             input logic [DW-1:0] base);
        int rd0, cd0, up0;
        push_expect(addr, resp, op, base);
        rd0 = rd_cnt; cd0 = cd_hs_cnt; up0 = upd_hs_cnt;
        start_snoop(sn, addr, h, d, s);
        wait_done();
        check("rd_reads", rd_cnt - rd0, resp[0] ? NB : 0);
        check("cd_handshakes", cd_hs_cnt - cd0, resp[0] ? NB : 0);
        check("upd_handshakes", upd_hs_cnt - up0, (op != 2'b00) ? 1 : 0);
        $display("snoop %b addr %0h -> resp %b op %b", sn, addr, resp, op);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int cd0;
        rst_i = 1'b1; ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0;
        lookup_ready_i = 1'b0; lookup_rsp_valid_i = 1'b0;
        lookup_hit_i = 1'b0; lookup_dirty_i = 1'b0; lookup_shared_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ac_ready", ac_ready_o, 1'b0);
        check("rst_lookup_valid", lookup_valid_o, 1'b0);
        check("rst_cr_valid", cr_valid_o, 1'b0);
        check("rst_cd_valid", cd_valid_o, 1'b0);
        check("rst_upd_valid", upd_valid_o, 1'b0);
        check("rst_rd_en", rd_en_o, 1'b0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_ac_ready", ac_ready_o, 1'b1);

        // Miss, dirty ReadUnique, same under CD backpressure.
        run_snoop(4'b0001, 64'h1000, 1'b0, 1'b0, 1'b0, 5'b00000, 2'b00, 64'h0);
        run_snoop(4'b0111, 64'h2040, 1'b1, 1'b1, 1'b0, 5'b10101, 2'b01, 64'hA0);
        bp_on = 1;
        run_snoop(4'b0111, 64'h3080, 1'b1, 1'b1, 1'b0, 5'b10101, 2'b01, 64'hA0);
        bp_on = 0;

        // CleanShared clean/dirty, unsupported, MakeInvalid with random CR/upd ready.
        rand_on = 1;
        run_snoop(4'b1000, 64'h4000, 1'b1, 1'b0, 1'b0, 5'b01000, 2'b00, 64'h0);
        run_snoop(4'b1000, 64'h40C0, 1'b1, 1'b1, 1'b1, 5'b01101, 2'b10, 64'hC0);
        run_snoop(4'b0101, 64'h5000, 1'b1, 1'b0, 1'b0, 5'b00010, 2'b00, 64'h0);
        run_snoop(4'b1101, 64'h5040, 1'b1, 1'b1, 1'b0, 5'b00000, 2'b01, 64'h0);
        rand_on = 0;

        // Reset in the middle of a CD burst.
        push_expect(64'h6000, 5'b10101, 2'b01, 64'hA0);
        cd0 = cd_hs_cnt;
        start_snoop(4'b0111, 64'h6000, 1'b1, 1'b1, 1'b0);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            #1;
            if (cd_hs_cnt - cd0 >= 2) begin ok = 1; break; end
        end
        if (!ok) check("rst_mid_timeout", 0, 1);
        force_cd_low = 1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("mid_rst_beats", cd_hs_cnt - cd0, 2);
        check("mid_rst_ac_ready", ac_ready_o, 1'b0);
        check("mid_rst_cd_valid", cd_valid_o, 1'b0);
        check("mid_rst_cr_valid", cr_valid_o, 1'b0);
        check("mid_rst_upd_valid", upd_valid_o, 1'b0);
        check("mid_rst_lookup_valid", lookup_valid_o, 1'b0);
        check("mid_rst_rd_en", rd_en_o, 1'b0);
        exp_cr.delete(); exp_cd.delete(); exp_upd.delete();
        rst_i = 1'b0;
        force_cd_low = 0;
        @(negedge clk_i);
        check("post_rst_ac_ready", ac_ready_o, 1'b1);
        $display("reset during CD burst after 2 beats");

        run_snoop(4'b0000, 64'h7000, 1'b1, 1'b0, 1'b1, 5'b01001, 2'b00, 64'hB0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ace_snoop_responder.md
Name: ace_snoop_responder

Overview:
- Cached-master-side responder for the ACE snoop channel. Accepts AC snoop requests from the CCU snoop crossbar and looks up line state in the local cache through a lookup port.
- Returns a CR response and, when required, a CD data burst.
- Issues the resulting cache state update (invalidate/clean) after data is sent.
- One snoop outstanding at a time.

Parameters:
AddrWidth, 64, AC address width
DataWidth, 64, CD data width
CdBeats, 4, CD beats per cache line (power of 2, >=1)
BeatIdxWidth, $clog2(CdBeats) (min 1), derived beat-index width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
ac_valid_i  in  1  snoop request valid
ac_ready_o  out  1  snoop request ready
ac_addr_i  in  AddrWidth  snoop address
ac_snoop_i  in  4  ACSNOOP encoding
ac_prot_i  in  3  ignored
cr_valid_o  out  1  snoop response valid
cr_ready_i  in  1  snoop response ready
cr_resp_o  out  5  {WasUnique, IsShared, PassDirty, Error, DataTransfer}
cd_valid_o  out  1  snoop data valid
cd_ready_i  in  1  snoop data ready
cd_data_o  out  DataWidth  snoop data
cd_last_o  out  1  last CD beat
lookup_valid_o  out  1  tag lookup request
lookup_ready_i  in  1  lookup accepted
lookup_addr_o  out  AddrWidth  lookup address (latched AC addr)
lookup_rsp_valid_i  in  1  lookup result valid (any cycles after accept)
lookup_hit_i, lookup_dirty_i, lookup_shared_i  in  1 each  line state
rd_en_o  out  1  data array read; data returns exactly 1 cycle later
rd_beat_o  out  BeatIdxWidth  beat index of read
rd_data_i  in  DataWidth  read data (cycle after rd_en_o)
upd_valid_o  out  1  state update request
upd_ready_i  in  1  update accepted
upd_addr_o  out  AddrWidth  latched AC addr
upd_op_o  out  2  01 invalidate, 10 make clean-shared

Behaviour:
- Reset: all *_valid_o, rd_en_o, ac_ready_o = 0. FSM -> IDLE, beat counters = 0, data buffer empty.
- Reset mid-operation: abandon the transaction with no further outputs. A pending CR/CD/update is dropped.
- FSM states: IDLE -> LOOKUP -> WAIT_RSP -> CR -> DATA (only if DataTransfer) -> UPD (only if op != none) -> IDLE.
- IDLE: ac_ready_o=1. On AC handshake, latch addr/snoop and go to LOOKUP (lookup_valid_o=1 the next cycle).
- LOOKUP: hold lookup_valid_o/addr stable until lookup_ready_i.
- WAIT_RSP: on lookup_rsp_valid_i, latch hit/dirty/shared, compute resp/op, go to CR.
- Response table (h=hit, d=dirty, s=shared):
  - miss: resp=0, op none.
  - ReadOnce 0000: DT=1, IsShared=1, op none.
  - ReadShared 0001 / ReadClean 0010 / ReadNotSharedDirty 0011: DT=1, IsShared=1, PassDirty=d; op=clean if d else none.
  - ReadUnique 0111: DT=1, PassDirty=d, WasUnique=!s; op invalidate.
  - CleanShared 1000: DT=d, PassDirty=d, IsShared=1; op=clean if d else none.
  - CleanInvalid 1001: DT=d, PassDirty=d, WasUnique=!s; op invalidate.
  - MakeInvalid 1101: resp=0; op invalidate.
  - Any other encoding: Error=1, op none, no data.
- CR: cr_valid_o held with resp stable until cr_ready_i. Next state is DATA if DT, else UPD if op, else IDLE.
- DATA:
  - Read beats 0..CdBeats-1 in order into a 2-entry buffer.
  - rd_en_o is issued only when the buffer has a free slot accounting for the in-flight read.
  - With cd_ready_i held 1, CD is gap-free after the first beat. The first cd_valid_o comes 2 cycles after DATA entry.
  - cd_last_o=1 on beat CdBeats-1.
  - CD data/last stay stable while cd_valid_o && !cd_ready_i.
- UPD: upd_valid_o held until upd_ready_i. Entered only after the last CD handshake, so the line is never modified mid-read.
- Back-to-back: ac_ready_o returns 1 the cycle after the final handshake of the transaction.
- CdBeats=1: the single beat has cd_last_o=1.

Test Plan:
- Miss: AC ReadShared addr 0x1000, hit=0 -> CR resp=5'b00000; no CD, no upd, no rd_en_o; ac_ready_o=1 again afterwards.
- Dirty ReadUnique: hit=1, d=1, s=0, rd_data beats 0xA0..0xA3 -> CR resp=5'b10101; CD 0xA0,0xA1,0xA2,0xA3 with last on the 4th; then upd_op=01, upd_addr=AC addr.
- CD backpressure: same as the previous case with cd_ready_i toggling 1,0,0,1,... -> data/last stable while stalled; no beat lost or duplicated; total 4 handshakes.
- CleanShared clean line: hit=1, d=0 -> resp=5'b01000; no CD, no upd. Dirty line -> resp=5'b01101; 4 CD beats; upd_op=10.
- Unsupported snoop 0101 on hit -> resp=5'b00010; no CD, no upd. MakeInvalid hit -> resp=0; upd_op=01.
- Reset asserted during DATA after 2 beats -> next cycle all valids 0, ac_ready_o=0. After release, IDLE with ac_ready_o=1. A new ReadOnce completes normally with 4 beats.
